// File: rtl/sd_init_seq.sv
`default_nettype none
// +------------------------------------------------------------------------------+
// | sd_init_seq : SD-card SPI-mode init sequencer in front of spi_microSD        |
// | Rev 1.0                                                                      |
// +------------------------------------------------------------------------------+
module sd_init_seq #(
    parameter logic [2:0]  CLKDIV_INIT    = 3'b101,
    parameter int          DUMMY_WORDS    = 2,
    parameter int          CMD0_RETRIES   = 8,
    parameter int          ACMD41_RETRIES = 1000,
    parameter int          TIMEOUT_CYC    = 65535,
    parameter logic [31:0] BLOCK_LEN      = 32'd512
) (
    input  logic        spi_clk_i,
    input  logic        spi_rst_i,
    input  logic        spi_init_i,
    input  logic [47:0] spi_datamicro_i,
    input  logic [7:0]  spi_statusregmicro_i,
    input  logic [7:0]  R1,
    input  logic [31:0] spi_ocr_i,
    input  logic [2:0]  spi_flagreg_i,
    output logic [47:0] spi_datainit_o,
    output logic [8:0]  spi_statusreginit_o,
    output logic        spi_initdone_o,
    output logic        spi_initerr_o,
    output logic [2:0]  spi_errcode_o,
    output logic        spi_sdhc_o
);

    localparam int DW   = $clog2(DUMMY_WORDS + 1);
    localparam int C0W  = $clog2(CMD0_RETRIES + 1);
    localparam int A41W = $clog2(ACMD41_RETRIES + 1);
    localparam int TW   = $clog2(TIMEOUT_CYC + 1);

    localparam logic [DW-1:0]   DUMMY_LAST = DW'(DUMMY_WORDS - 1);
    localparam logic [DW-1:0]   DUMMY_ONE  = DW'(1);
    localparam logic [C0W-1:0]  C0_MAX     = C0W'(CMD0_RETRIES);
    localparam logic [C0W-1:0]  C0_ONE     = C0W'(1);
    localparam logic [A41W-1:0] A41_MAX    = A41W'(ACMD41_RETRIES);
    localparam logic [A41W-1:0] A41_ONE    = A41W'(1);
    localparam logic [TW-1:0]   TMO_MAX    = TW'(TIMEOUT_CYC);
    localparam logic [TW-1:0]   TMO_ONE    = TW'(1);

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_WAIT   = 4'd1;
    localparam logic [3:0] S_CMD0   = 4'd2;
    localparam logic [3:0] S_CMD8   = 4'd3;
    localparam logic [3:0] S_CMD55  = 4'd4;
    localparam logic [3:0] S_ACMD41 = 4'd5;
    localparam logic [3:0] S_CMD58  = 4'd6;
    localparam logic [3:0] S_CMD59  = 4'd7;
    localparam logic [3:0] S_CMD16  = 4'd8;
    localparam logic [3:0] S_DONE   = 4'd9;
    localparam logic [3:0] S_ERR    = 4'd10;

    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_CMD0    = 3'd1;
    localparam logic [2:0] ERR_ECHO    = 3'd2;
    localparam logic [2:0] ERR_ACMD41  = 3'd3;
    localparam logic [2:0] ERR_TIMEOUT = 3'd4;
    localparam logic [2:0] ERR_R1      = 3'd5;

    localparam logic [7:0] R1_READY   = 8'h00;
    localparam logic [7:0] R1_IDLE    = 8'h01;
    localparam logic [7:0] R1_ILLEGAL = 8'h05;

    localparam logic [47:0] W_DUMMY  = 48'hFFFF_FFFF_FFFF;
    localparam logic [47:0] W_CMD0   = 48'h40_0000_0000_95;
    localparam logic [47:0] W_CMD8   = 48'h48_0000_01AA_87;
    localparam logic [47:0] W_CMD55  = 48'h77_0000_0000_01;
    localparam logic [47:0] W_A41_V2 = 48'h69_4000_0000_77;
    localparam logic [47:0] W_A41_V1 = 48'h69_0000_0000_77;
    localparam logic [47:0] W_CMD58  = 48'h7A_0000_0000_01;
    localparam logic [47:0] W_CMD59  = 48'h7B_0000_0000_FF;
    localparam logic [47:0] W_CMD16  = {8'h50, BLOCK_LEN, 8'hFF};

    logic [3:0]      state_q, state_d;
    logic [DW-1:0]   dummy_q, dummy_d;
    logic [C0W-1:0]  c0_q, c0_d, c0_inc;
    logic [A41W-1:0] a41_q, a41_d, a41_inc;
    logic [TW-1:0]   tmo_q, tmo_d, tmo_inc;
    logic            v2_q, v2_d;
    logic            sdhc_q, sdhc_d;
    logic [2:0]      errcode_q, errcode_d;
    logic            initdone_q, initerr_q;
    logic [47:0]     cmd_q;

    logic            w_cmd_done;
    logic            w_cmd_state;
    logic            w_host;
    logic            w_unused;

    assign w_cmd_done  = spi_flagreg_i[1];
    assign w_host      = (state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR);
    assign w_cmd_state = !w_host && (state_q != S_WAIT);
    assign w_unused    = ^{spi_flagreg_i[2], spi_flagreg_i[0], spi_ocr_i[31], spi_ocr_i[29:12]};

    // All retry/timeout counters saturate rather than wrap.
    assign c0_inc  = (c0_q  == C0_MAX)  ? c0_q  : c0_q  + C0_ONE;
    assign a41_inc = (a41_q == A41_MAX) ? a41_q : a41_q + A41_ONE;
    assign tmo_inc = (tmo_q == TMO_MAX) ? tmo_q : tmo_q + TMO_ONE;

    function automatic logic [47:0] cmd_word(input logic [3:0] st, input logic v2);
        logic [47:0] w;
        case (st)
            S_WAIT:   w = W_DUMMY;
            S_CMD0:   w = W_CMD0;
            S_CMD8:   w = W_CMD8;
            S_CMD55:  w = W_CMD55;
            S_ACMD41: w = v2 ? W_A41_V2 : W_A41_V1;
            S_CMD58:  w = W_CMD58;
            S_CMD59:  w = W_CMD59;
            S_CMD16:  w = W_CMD16;
            default:  w = '0;
        endcase
        return w;
    endfunction

    always_comb begin
        state_d   = state_q;
        dummy_d   = dummy_q;
        c0_d      = c0_q;
        a41_d     = a41_q;
        tmo_d     = tmo_q;
        v2_d      = v2_q;
        sdhc_d    = sdhc_q;
        errcode_d = errcode_q;

        case (state_q)
            S_IDLE: begin
                if (spi_init_i) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (w_cmd_done) begin
                    if (dummy_q == DUMMY_LAST) begin
                        dummy_d = '0;
                        state_d = S_CMD0;
                    end else begin
                        dummy_d = dummy_q + DUMMY_ONE;
                    end
                end
            end
            S_CMD0: begin
                if (w_cmd_done) begin
                    if (R1 == R1_IDLE) begin
                        state_d = S_CMD8;
                    end else begin
                        c0_d = c0_inc;
                        if (c0_inc == C0_MAX) begin
                            state_d   = S_ERR;
                            errcode_d = ERR_CMD0;
                        end
                    end
                end
            end
            S_CMD8: begin
                if (w_cmd_done) begin
                    if (R1 == R1_IDLE && spi_ocr_i[11:0] == 12'h1AA) begin
                        v2_d    = 1'b1;
                        state_d = S_CMD55;
                    end else if (R1 == R1_IDLE) begin
                        state_d   = S_ERR;
                        errcode_d = ERR_ECHO;
                    end else if (R1 == R1_ILLEGAL) begin
                        v2_d    = 1'b0;
                        state_d = S_CMD55;
                    end else begin
                        state_d   = S_ERR;
                        errcode_d = ERR_R1;
                    end
                end
            end
            S_CMD55: begin
                if (w_cmd_done) begin
                    if (R1 == R1_READY || R1 == R1_IDLE) begin
                        state_d = S_ACMD41;
                    end else begin
                        state_d   = S_ERR;
                        errcode_d = ERR_R1;
                    end
                end
            end
            S_ACMD41: begin
                if (w_cmd_done) begin
                    if (R1 == R1_READY) begin
                        state_d = S_CMD58;
                    end else if (R1 == R1_IDLE) begin
                        a41_d = a41_inc;
                        if (a41_inc == A41_MAX) begin
                            state_d   = S_ERR;
                            errcode_d = ERR_ACMD41;
                        end else begin
                            state_d = S_CMD55;
                        end
                    end else begin
                        state_d   = S_ERR;
                        errcode_d = ERR_R1;
                    end
                end
            end
            S_CMD58: begin
                if (w_cmd_done) begin
                    if (R1 == R1_READY) begin
                        // A v1 card has no CCS bit; whatever OCR says is ignored.
                        sdhc_d  = v2_q & spi_ocr_i[30];
                        state_d = S_CMD59;
                    end else begin
                        state_d   = S_ERR;
                        errcode_d = ERR_R1;
                    end
                end
            end
            S_CMD59: begin
                if (w_cmd_done) begin
                    if (R1 == R1_READY) begin
                        state_d = sdhc_q ? S_DONE : S_CMD16;
                    end else begin
                        state_d   = S_ERR;
                        errcode_d = ERR_R1;
                    end
                end
            end
            S_CMD16: begin
                if (w_cmd_done) begin
                    if (R1 == R1_READY) begin
                        state_d = S_DONE;
                    end else begin
                        state_d   = S_ERR;
                        errcode_d = ERR_R1;
                    end
                end
            end
            default: ;
        endcase

        // Timeout runs from command issue; a response pulse or any state change restarts it.
        if (w_cmd_state && !w_cmd_done) begin
            tmo_d = tmo_inc;
            if (tmo_inc == TMO_MAX) begin
                state_d   = S_ERR;
                errcode_d = ERR_TIMEOUT;
            end
        end else begin
            tmo_d = '0;
        end
        if (state_d != state_q) tmo_d = '0;

        if (!spi_init_i && !w_host) begin
            state_d   = S_IDLE;
            dummy_d   = '0;
            c0_d      = '0;
            a41_d     = '0;
            tmo_d     = '0;
            v2_d      = 1'b0;
            sdhc_d    = 1'b0;
            errcode_d = ERR_NONE;
        end
    end

    always_ff @(posedge spi_clk_i) begin
        if (spi_rst_i) begin
            state_q    <= S_IDLE;
            dummy_q    <= '0;
            c0_q       <= '0;
            a41_q      <= '0;
            tmo_q      <= '0;
            v2_q       <= 1'b0;
            sdhc_q     <= 1'b0;
            errcode_q  <= ERR_NONE;
            initdone_q <= 1'b0;
            initerr_q  <= 1'b0;
            cmd_q      <= '0;
        end else begin
            state_q    <= state_d;
            dummy_q    <= dummy_d;
            c0_q       <= c0_d;
            a41_q      <= a41_d;
            tmo_q      <= tmo_d;
            v2_q       <= v2_d;
            sdhc_q     <= sdhc_d;
            errcode_q  <= errcode_d;
            initdone_q <= (state_d == S_DONE);
            initerr_q  <= (state_d == S_ERR);
            cmd_q      <= cmd_word(state_d, v2_d);
        end
    end

    always_comb begin
        if (w_host) begin
            spi_datainit_o      = spi_datamicro_i;
            spi_statusreginit_o = {spi_statusregmicro_i[7:1], 1'b0, spi_statusregmicro_i[0]};
        end else begin
            spi_datainit_o      = cmd_q;
            spi_statusreginit_o = {CLKDIV_INIT, 3'b000, 1'b1, (state_q == S_WAIT), 1'b1};
        end
    end

    assign spi_initdone_o = initdone_q;
    assign spi_initerr_o  = initerr_q;
    assign spi_errcode_o  = errcode_q;
    assign spi_sdhc_o     = sdhc_q;

endmodule
`default_nettype wire

// File: tb/tb_sd_init_seq.sv
`default_nettype none
// +------------------------------------------------------------------------------+
// | tb_sd_init_seq : card-emulating self-checking bench for sd_init_seq          |
// | Rev 1.0                                                                      |
// +------------------------------------------------------------------------------+
module tb_sd_init_seq;

    localparam int DUMMY = 2;
    localparam int C0R   = 3;
    localparam int A41R  = 5;
    localparam int TMO   = 200;

    localparam logic [47:0] W_ONES   = 48'hFFFF_FFFF_FFFF;
    localparam logic [47:0] W_CMD0   = 48'h40_0000_0000_95;
    localparam logic [47:0] W_CMD8   = 48'h48_0000_01AA_87;
    localparam logic [47:0] W_CMD55  = 48'h77_0000_0000_01;
    localparam logic [47:0] W_A41_V2 = 48'h69_4000_0000_77;
    localparam logic [47:0] W_A41_V1 = 48'h69_0000_0000_77;
    localparam logic [47:0] W_CMD58  = 48'h7A_0000_0000_01;
    localparam logic [47:0] W_CMD59  = 48'h7B_0000_0000_FF;
    localparam logic [47:0] W_CMD16  = 48'h50_0000_0200_FF;
    localparam logic [8:0]  ST_CMD   = 9'h145;
    localparam logic [8:0]  ST_WAIT  = 9'h147;

    logic        clk = 1'b0;
    logic        rst, init;
    logic [47:0] dmicro;
    logic [7:0]  smicro, r1;
    logic [31:0] ocr;
    logic [2:0]  flag;
    logic [47:0] datainit;
    logic [8:0]  statinit;
    logic        done, err, sdhc;
    logic [2:0]  code;

    sd_init_seq #(
        .CLKDIV_INIT(3'b101), .DUMMY_WORDS(DUMMY), .CMD0_RETRIES(C0R),
        .ACMD41_RETRIES(A41R), .TIMEOUT_CYC(TMO), .BLOCK_LEN(32'd512)
    ) dut (
        .spi_clk_i(clk), .spi_rst_i(rst), .spi_init_i(init),
        .spi_datamicro_i(dmicro), .spi_statusregmicro_i(smicro),
        .R1(r1), .spi_ocr_i(ocr), .spi_flagreg_i(flag),
        .spi_datainit_o(datainit), .spi_statusreginit_o(statinit),
        .spi_initdone_o(done), .spi_initerr_o(err),
        .spi_errcode_o(code), .spi_sdhc_o(sdhc)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [47:0] obs_w[$];
    logic [8:0]  obs_s[$];
    logic [47:0] exp_w[$];
    int          exp_code;
    bit          exp_sdhc;

    // Emulated card personality: typ 0=v2, 1=v1, 2=bad CMD8 echo, 3=v2 that rejects CMD55
    int c_fails, c_typ, c_busy;
    bit c_ccs;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] host_status(input logic [7:0] s);
        return {s[7:1], 1'b0, s[0]};
    endfunction

    // Expected command stream and outcome, derived from the card personality.
    function automatic void build_expected(input int fails, input int typ, input int busy, input bit ccs);
        bit v2;
        exp_w    = {};
        exp_code = 0;
        exp_sdhc = 1'b0;
        for (int i = 0; i < DUMMY; i++) exp_w.push_back(W_ONES);
        if (fails >= C0R) begin
            for (int i = 0; i < C0R; i++) exp_w.push_back(W_CMD0);
            exp_code = 1;
            return;
        end
        for (int i = 0; i <= fails; i++) exp_w.push_back(W_CMD0);
        exp_w.push_back(W_CMD8);
        if (typ == 2) begin
            exp_code = 2;
            return;
        end
        v2 = (typ != 1);
        for (int k = 0; ; k++) begin
            exp_w.push_back(W_CMD55);
            if (typ == 3) begin
                exp_code = 5;
                return;
            end
            exp_w.push_back(v2 ? W_A41_V2 : W_A41_V1);
            if (k == busy) break;
            if (k + 1 == A41R) begin
                exp_code = 3;
                return;
            end
        end
        exp_w.push_back(W_CMD58);
        exp_w.push_back(W_CMD59);
        exp_sdhc = v2 && ccs;
        if (!exp_sdhc) exp_w.push_back(W_CMD16);
    endfunction

    task automatic respond(input logic [47:0] w, output logic [7:0] rr, output logic [31:0] oo);
        oo = $urandom;
        rr = 8'hFF;
        if (w != W_ONES) begin
            case (int'(w[45:40]))
                0: begin
                    if (c_fails > 0) begin
                        c_fails--;
                        rr = 8'hFF;
                    end else rr = 8'h01;
                end
                8: begin
                    if (c_typ == 1) rr = 8'h05;
                    else begin
                        rr = 8'h01;
                        oo[11:0] = (c_typ == 2) ? 12'h0AA : 12'h1AA;
                    end
                end
                55: rr = (c_typ == 3) ? 8'h04 : 8'h01;
                41: begin
                    if (c_busy > 0) begin
                        c_busy--;
                        rr = 8'h01;
                    end else rr = 8'h00;
                end
                58: begin
                    rr = 8'h00;
                    oo = c_ccs ? 32'hC0FF_8000 : 32'h80FF_8000;
                end
                59, 16: rr = 8'h00;
                default: rr = 8'hFF;
            endcase
        end
    endtask

    // Serve commands until done/err, or until command index stop_idx is presented.
    task automatic run_card(input int stop_idx, output bit stopped);
        logic [47:0] w;
        logic [7:0]  rr;
        logic [31:0] oo;
        int          guard;
        guard   = 0;
        stopped = 1'b0;
        obs_w   = {};
        obs_s   = {};
        while (!done && !err) begin
            if (guard > 200) begin
                chk("cmd_budget_expired", 64'(guard), 64'(0));
                break;
            end
            w = datainit;
            if (stop_idx >= 0 && w != W_ONES && int'(w[45:40]) == stop_idx) begin
                stopped = 1'b1;
                break;
            end
            obs_w.push_back(w);
            obs_s.push_back(statinit);
            respond(w, rr, oo);
            repeat ($urandom_range(0, 3)) begin
                flag = 3'($urandom) & 3'b101;
                r1   = $urandom;
                step();
            end
            r1   = rr;
            ocr  = oo;
            flag = 3'b010;
            step();
            flag = 3'b000;
            r1   = $urandom;
            ocr  = $urandom;
            guard++;
        end
    endtask

    task automatic compare_run(input string tag);
        int n;
        chk({tag, "_ncmd"}, 64'(obs_w.size()), 64'(exp_w.size()));
        n = (obs_w.size() < exp_w.size()) ? obs_w.size() : exp_w.size();
        for (int i = 0; i < n; i++) begin
            chk({tag, "_word"}, 64'(obs_w[i]), 64'(exp_w[i]));
            chk({tag, "_stat"}, 64'(obs_s[i]), 64'((exp_w[i] == W_ONES) ? ST_WAIT : ST_CMD));
        end
        chk({tag, "_done"}, 64'(done), 64'(exp_code == 0));
        chk({tag, "_err"},  64'(err),  64'(exp_code != 0));
        chk({tag, "_code"}, 64'(code), 64'(exp_code));
        chk({tag, "_sdhc"}, 64'(sdhc), 64'(exp_sdhc));
    endtask

    task automatic set_card(input int fails, input int typ, input int busy, input bit ccs);
        c_fails = fails;
        c_typ   = typ;
        c_busy  = busy;
        c_ccs   = ccs;
        build_expected(fails, typ, busy, ccs);
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        init = 1'b0;
        flag = 3'b000;
        repeat (2) step();
        rst = 1'b0;
        step();
    endtask

    task automatic run_scenario(input int fails, input int typ, input int busy, input bit ccs, input string tag);
        bit stopped;
        do_reset();
        set_card(fails, typ, busy, ccs);
        init = 1'b1;
        step();
        run_card(-1, stopped);
        compare_run(tag);
    endtask

    initial begin
        bit stopped;
        int n;
        rst    = 1'b1;
        init   = 1'b0;
        flag   = 3'b000;
        r1     = 8'h00;
        ocr    = 32'h0;
        dmicro = {16'($urandom), 32'($urandom)};
        smicro = 8'($urandom);
        repeat (3) step();
        rst = 1'b0;
        step();

        chk("rst_done", 64'(done), 64'(0));
        chk("rst_err",  64'(err),  64'(0));
        chk("rst_code", 64'(code), 64'(0));
        chk("rst_sdhc", 64'(sdhc), 64'(0));
        chk("rst_data", 64'(datainit), 64'(dmicro));
        chk("rst_stat", 64'(statinit), 64'(host_status(smicro)));

        run_scenario(0, 0, 1, 1'b1, "v2_sdhc");

        // Passthrough and stickiness in DONE.
        smicro = 8'hA5;
        dmicro = 48'h1234_5678_9ABC;
        step();
        chk("done_stat_a5", 64'(statinit), 64'h149);
        chk("done_data",    64'(datainit), 64'h1234_5678_9ABC);
        flag = 3'b010;
        r1   = 8'hFF;
        init = 1'b0;
        step();
        flag = 3'b000;
        repeat (3) step();
        chk("done_sticky", 64'(done), 64'(1));
        chk("done_sdhc",   64'(sdhc), 64'(1));
        chk("done_noerr",  64'(err),  64'(0));

        run_scenario(0, 1, int'($urandom_range(0, 3)), 1'b1, "v1_card");
        run_scenario(0, 0, 1000, 1'b0, "acmd41_stuck");
        run_scenario(7, 0, 0, 1'b0, "cmd0_exhaust");
        run_scenario(0, 2, 0, 1'b0, "bad_echo");
        run_scenario(1, 3, 0, 1'b0, "bad_cmd55");
        run_scenario(0, 0, A41R - 1, 1'b0, "acmd41_last_try");

        for (int s = 0; s < 10; s++) begin
            run_scenario(int'($urandom_range(0, C0R + 1)), int'($urandom_range(0, 3)),
                         int'($urandom_range(0, A41R + 1)), 1'($urandom), "random");
        end

        // Timeout while CMD0 waits for a response.
        do_reset();
        set_card(0, 0, 0, 1'b0);
        init = 1'b1;
        step();
        run_card(0, stopped);
        chk("tmo_reached_cmd0", 64'(stopped), 64'(1));
        n = 0;
        while (!err && n < TMO + 50) begin
            step();
            n++;
        end
        chk("tmo_cycles", 64'(n),    64'(TMO));
        chk("tmo_code",   64'(code), 64'(4));
        chk("tmo_done",   64'(done), 64'(0));

        // Abort in ACMD41, then restart without reset.
        do_reset();
        set_card(0, 0, 3, 1'b1);
        init = 1'b1;
        step();
        run_card(41, stopped);
        chk("abort_reached_a41", 64'(stopped), 64'(1));
        dmicro = {16'($urandom), 32'($urandom)};
        smicro = 8'($urandom);
        init   = 1'b0;
        step();
        chk("abort_data", 64'(datainit), 64'(dmicro));
        chk("abort_stat", 64'(statinit), 64'(host_status(smicro)));
        chk("abort_done", 64'(done), 64'(0));
        chk("abort_err",  64'(err),  64'(0));
        repeat (2) step();
        set_card(0, 0, 0, 1'b0);
        init = 1'b1;
        step();
        run_card(-1, stopped);
        compare_run("restart");

        // Synchronous reset during CMD8 wins over a simultaneous response.
        do_reset();
        set_card(0, 0, 0, 1'b1);
        init = 1'b1;
        step();
        run_card(8, stopped);
        chk("rst8_reached_cmd8", 64'(stopped), 64'(1));
        rst  = 1'b1;
        flag = 3'b010;
        r1   = 8'h01;
        ocr  = 32'h0000_01AA;
        step();
        rst  = 1'b0;
        flag = 3'b000;
        chk("rst8_data", 64'(datainit), 64'(dmicro));
        chk("rst8_stat", 64'(statinit), 64'(host_status(smicro)));
        chk("rst8_done", 64'(done), 64'(0));
        step();
        chk("rst8_rewait", 64'(statinit), 64'(ST_WAIT));
        run_card(-1, stopped);
        compare_run("after_rst8");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
